// File: rtl/slice_seq_pkg.sv
// Shared types, default sizes and the mask search helper for the slice sequencer.
package slice_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap,
    StDone
  } seq_state_e;

  localparam int unsigned DefSliceW    = 12;
  localparam int unsigned DefNumSlices = 3;
  localparam int unsigned DefTimeout   = 8;

  // Widest mask the search helper handles; callers zero-extend into it.
  localparam int unsigned MaxSlices = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } bit_search_t;

  // Lowest set bit of mask at position >= from.
  function automatic bit_search_t next_set_bit(input logic [MaxSlices-1:0] mask,
                                               input int unsigned from);
    bit_search_t res;
    res = '0;
    for (int unsigned i = 0; i < MaxSlices; i++) begin
      if (!res.found && (i >= from) && mask[i]) begin
        res.found = 1'b1;
        res.idx   = i[4:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/slice_timeout_ctr.sv
// Loadable up-counter with clear and enable; expire_o flags the last allowed cycle.
module slice_timeout_ctr #(
  parameter  int unsigned TIMEOUT = 8,
  localparam int unsigned CntW    = $clog2(TIMEOUT + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            expire_o
);

  logic [CntW-1:0] cnt_q;

  // Clear beats load, load beats increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expire_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/slice_op_sequencer.sv
// Time-multiplexes one shared slice unit across the enabled slices of an operand pair
// and assembles the wide result plus per-slice timeout flags.
module slice_op_sequencer
  import slice_seq_pkg::*;
#(
  parameter int unsigned SLICE_W    = DefSliceW,
  parameter int unsigned NUM_SLICES = DefNumSlices,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                          CK,
  input  logic                          RST,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [NUM_SLICES*SLICE_W-1:0] A,
  input  logic [NUM_SLICES*SLICE_W-1:0] B,
  input  logic [NUM_SLICES-1:0]         MASK,
  output logic                          SL_VALID,
  output logic [SLICE_W-1:0]            SL_A,
  output logic [SLICE_W-1:0]            SL_B,
  input  logic [SLICE_W-1:0]            SL_C,
  input  logic                          SL_DONE,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [NUM_SLICES*SLICE_W-1:0] C,
  output logic [NUM_SLICES-1:0]         ERR
);

  localparam int unsigned IdxW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef logic [NUM_SLICES-1:0][SLICE_W-1:0] slices_t;

  seq_state_e            state_q;
  slices_t               a_in, b_in;
  slices_t               a_q, b_q, c_q;
  logic [NUM_SLICES-1:0] mask_q, err_q;
  logic [IdxW-1:0]       idx_q;
  logic                  sl_valid_q, out_valid_q;
  logic [SLICE_W-1:0]    sl_a_q, sl_b_q;

  bit_search_t           first_s, next_s;
  logic [IdxW-1:0]       first_idx, next_idx;
  logic                  unused_search_bits;
  logic                  issuing, expire, slice_done;

  assign a_in = A;
  assign b_in = B;

  // First enabled slice of the incoming mask, and the next one above the current slice.
  always_comb begin
    first_s = next_set_bit(MaxSlices'(MASK), 0);
    next_s  = next_set_bit(MaxSlices'(mask_q), 32'(idx_q) + 32'd1);
  end

  assign first_idx          = first_s.idx[IdxW-1:0];
  assign next_idx           = next_s.idx[IdxW-1:0];
  assign unused_search_bits = ^{first_s.idx, next_s.idx};

  assign issuing    = (state_q == StIssue);
  // A slice completes on acknowledge or on its last allowed cycle.
  assign slice_done = issuing && (SL_DONE || expire);

  slice_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk_i      (CK),
    .rst_i      (RST),
    .clr_i      (!issuing || slice_done),
    .en_i       (issuing),
    .load_i     (1'b0),
    .load_val_i ('0),
    .expire_o   (expire)
  );

  // Sequencer FSM with registered slice-unit and result handshakes.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      mask_q      <= '0;
      c_q         <= '0;
      err_q       <= '0;
      idx_q       <= '0;
      sl_valid_q  <= 1'b0;
      sl_a_q      <= '0;
      sl_b_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (IN_VALID) begin
            a_q    <= a_in;
            b_q    <= b_in;
            mask_q <= MASK;
            c_q    <= '0;
            err_q  <= '0;
            if (first_s.found) begin
              idx_q      <= first_idx;
              sl_valid_q <= 1'b1;
              sl_a_q     <= a_in[first_idx];
              sl_b_q     <= b_in[first_idx];
              state_q    <= StIssue;
            end else begin
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StIssue: begin
          if (slice_done) begin
            // Acknowledge wins over a coincident timeout.
            c_q[idx_q] <= SL_DONE ? SL_C : '0;
            if (!SL_DONE) begin
              err_q[idx_q] <= 1'b1;
            end
            sl_valid_q <= 1'b0;
            if (next_s.found) begin
              state_q <= StGap;
            end else begin
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StGap: begin
          idx_q      <= next_idx;
          sl_a_q     <= a_q[next_idx];
          sl_b_q     <= b_q[next_idx];
          sl_valid_q <= 1'b1;
          state_q    <= StIssue;
        end
        StDone: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign IN_READY  = (state_q == StIdle) && !RST;
  assign SL_VALID  = sl_valid_q;
  assign SL_A      = sl_a_q;
  assign SL_B      = sl_b_q;
  assign OUT_VALID = out_valid_q;
  assign C         = c_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_slice_op_sequencer.sv
// Randomized scoreboard bench for slice_op_sequencer with a slice-unit responder model.
module tb_slice_op_sequencer;

  localparam int TO = 8;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [35:0] A = '0;
  logic [35:0] B = '0;
  logic [2:0]  MASK = '0;
  logic        SL_VALID;
  logic [11:0] SL_A, SL_B;
  logic [11:0] SL_C = '0;
  logic        SL_DONE = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [35:0] C;
  logic [2:0]  ERR;

  slice_op_sequencer #(
    .SLICE_W   (12),
    .NUM_SLICES(3),
    .TIMEOUT   (TO)
  ) dut (
    .CK       (CK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A        (A),
    .B        (B),
    .MASK     (MASK),
    .SL_VALID (SL_VALID),
    .SL_A     (SL_A),
    .SL_B     (SL_B),
    .SL_C     (SL_C),
    .SL_DONE  (SL_DONE),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .C        (C),
    .ERR      (ERR)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  // d = number of SL_VALID cycles before the unit acknowledges; 0 = never acknowledges.
  typedef struct packed {
    logic [35:0]      a;
    logic [35:0]      b;
    logic [2:0]       mask;
    logic [2:0][3:0]  d;
    logic [2:0][11:0] c;
  } op_t;

  typedef struct packed {
    logic [11:0] sla;
    logic [11:0] slb;
    logic [11:0] c;
    logic [3:0]  d;
  } iss_t;

  typedef struct packed {
    logic [35:0] c;
    logic [2:0]  err;
    int          out_cyc;
  } res_t;

  iss_t iss_q[$];
  res_t res_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic op_t rand_op();
    op_t op;
    op.a    = {4'($urandom), $urandom};
    op.b    = {4'($urandom), $urandom};
    op.mask = 3'($urandom);
    for (int i = 0; i < 3; i++) begin
      op.d[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, TO)) : 4'd1;
      op.c[i] = 12'($urandom);
    end
    return op;
  endfunction

  // Drive one operation when the DUT is ready; record the expected slice issues and result.
  task automatic issue_op(input op_t op);
    int   g = 0;
    int   n = 0;
    int   busy = 0;
    iss_t is;
    res_t rs;
    while (IN_READY !== 1'b1 && g < 500) begin
      @(negedge CK);
      g++;
    end
    if (g >= 500) begin
      timeout_fail("in_ready_wait");
      return;
    end
    A = op.a;
    B = op.b;
    MASK = op.mask;
    IN_VALID = 1'b1;
    rs.c = '0;
    rs.err = '0;
    for (int i = 0; i < 3; i++) begin
      if (op.mask[i]) begin
        is.sla = op.a[i*12 +: 12];
        is.slb = op.b[i*12 +: 12];
        is.c   = op.c[i];
        is.d   = op.d[i];
        iss_q.push_back(is);
        n++;
        busy += (op.d[i] == 4'd0) ? TO : int'(op.d[i]);
        if (op.d[i] == 4'd0) rs.err[i] = 1'b1;
        else rs.c[i*12 +: 12] = op.c[i];
      end
    end
    // One cycle to enter ISSUE, each slice's busy cycles, one gap between slices.
    rs.out_cyc = (n == 0) ? cyc + 1 : cyc + 1 + busy + (n - 1);
    res_q.push_back(rs);
    @(negedge CK);
    IN_VALID = 1'b0;
    A = {4'($urandom), $urandom};
    B = {4'($urandom), $urandom};
    MASK = 3'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    while ((res_q.size() != 0 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1) && g < 3000) begin
      @(negedge CK);
      g++;
    end
    if (g >= 3000) timeout_fail("drain");
  endtask

  // Slice-unit responder: checks issued operands and issue length, acknowledges per plan.
  bit   r_active = 1'b0;
  int   r_cnt = 0;
  int   r_lim = 0;
  iss_t r_cur;
  always @(negedge CK) begin
    if (RST) begin
      r_active = 1'b0;
      SL_DONE = 1'b0;
    end else if (SL_VALID === 1'b1) begin
      if (!r_active) begin
        if (iss_q.size() == 0) begin
          timeout_fail("unexpected_issue");
          r_cur = '0;
          r_cur.d = 4'd1;
        end else begin
          r_cur = iss_q.pop_front();
        end
        r_active = 1'b1;
        r_cnt = 1;
        r_lim = (r_cur.d == 4'd0) ? TO : int'(r_cur.d);
        check("sl_a", 64'(SL_A), 64'(r_cur.sla));
        check("sl_b", 64'(SL_B), 64'(r_cur.slb));
      end else begin
        r_cnt++;
        check("sl_a_stable", 64'(SL_A), 64'(r_cur.sla));
        if (r_cnt == r_lim + 1) check("issue_overrun", 64'(r_cnt), 64'(r_lim));
      end
      SL_DONE = (r_cur.d != 4'd0) && (r_cnt == int'(r_cur.d));
      SL_C = SL_DONE ? r_cur.c : 12'($urandom);
    end else begin
      if (r_active) begin
        check("issue_len", 64'(r_cnt), 64'(r_lim));
        r_active = 1'b0;
      end
      // Noise on the acknowledge while no request is outstanding must be ignored.
      SL_DONE = 1'($urandom_range(0, 1));
      SL_C = 12'($urandom);
    end
  end

  // Result monitor: pops the scoreboard on each new result and checks it while held.
  bit   m_seen = 1'b0;
  int   m_hold = 0;
  res_t m_cur;
  always @(negedge CK) begin
    if (RST) begin
      m_seen = 1'b0;
      OUT_READY = 1'b0;
    end else if (OUT_VALID === 1'b1) begin
      if (!m_seen) begin
        if (res_q.size() == 0) begin
          timeout_fail("unexpected_out");
          m_cur = '0;
        end else begin
          m_cur = res_q.pop_front();
          check("c", 64'(C), 64'(m_cur.c));
          check("err", 64'(ERR), 64'(m_cur.err));
          check("out_latency", 64'(cyc), 64'(m_cur.out_cyc));
        end
        m_seen = 1'b1;
        m_hold = $urandom_range(0, 6);
      end else begin
        check("c_stable", 64'(C), 64'(m_cur.c));
        check("err_stable", 64'(ERR), 64'(m_cur.err));
        m_hold--;
      end
      check("in_ready_done", 64'(IN_READY), 64'd0);
      check("sl_valid_done", 64'(SL_VALID), 64'd0);
      OUT_READY = (m_hold <= 0);
    end else begin
      if (m_seen) check("in_ready_after_done", 64'(IN_READY), 64'd1);
      m_seen = 1'b0;
      OUT_READY = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    op_t op;
    int  g;

    RST = 1'b1;
    repeat (2) @(negedge CK);
    check("rst_in_ready", 64'(IN_READY), 64'd0);
    check("rst_sl_valid", 64'(SL_VALID), 64'd0);
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_sl_a", 64'(SL_A), 64'd0);
    check("rst_sl_b", 64'(SL_B), 64'd0);
    check("rst_c", 64'(C), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    RST = 1'b0;
    @(negedge CK);
    check("idle_in_ready", 64'(IN_READY), 64'd1);

    // Full mask, immediate acks.
    op = rand_op();
    op.mask = 3'b111;
    op.d = {4'd1, 4'd1, 4'd1};
    op.c = {12'h333, 12'h222, 12'h111};
    issue_op(op);
    // Sparse mask: slice 1 must never be issued.
    op = rand_op();
    op.a = 36'hABC_DEF_123;
    op.mask = 3'b101;
    op.d = {4'd1, 4'd1, 4'd1};
    issue_op(op);
    // Empty mask goes straight to the result.
    op = rand_op();
    op.mask = 3'b000;
    issue_op(op);
    // Slice 1 never acknowledges.
    op = rand_op();
    op.mask = 3'b111;
    op.d = {4'd1, 4'd0, 4'd1};
    issue_op(op);
    // Acknowledge on the last allowed cycle of every slice.
    op = rand_op();
    op.mask = 3'b111;
    op.d = {4'(TO), 4'(TO), 4'(TO)};
    issue_op(op);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge CK);
      issue_op(rand_op());
    end
    drain();

    // Reset in the middle of slice 1's issue window.
    op = rand_op();
    op.mask = 3'b111;
    op.d = {4'd1, 4'd0, 4'd1};
    issue_op(op);
    g = 0;
    while (!(SL_VALID === 1'b1 && iss_q.size() == 1) && g < 100) begin
      @(negedge CK);
      g++;
    end
    if (g >= 100) timeout_fail("reach_slice1");
    RST = 1'b1;
    @(negedge CK);
    iss_q.delete();
    res_q.delete();
    check("midrst_sl_valid", 64'(SL_VALID), 64'd0);
    check("midrst_out_valid", 64'(OUT_VALID), 64'd0);
    check("midrst_c", 64'(C), 64'd0);
    check("midrst_err", 64'(ERR), 64'd0);
    check("midrst_in_ready", 64'(IN_READY), 64'd0);
    RST = 1'b0;
    @(negedge CK);
    check("postrst_in_ready", 64'(IN_READY), 64'd1);
    op = rand_op();
    op.mask = 3'b111;
    issue_op(op);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
